alu_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one instance of the team's 32-bit ALU between two requesters, for example the integer execute stage and the branch/address unit. Each requester has a valid/ready request channel and a valid/ready response channel. At most one operation is accepted per cycle. Results are registered, so latency is one cycle, and each result is held per requester until that requester consumes it.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and the
// shared-ALU arbiter.
//   reqN_*  : valid/ready request channel carrying a, b, op and tag
//   rspN_*  : valid/ready response channel carrying result, zero and tag
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_a, req0_b;
  logic [3:0]       req0_op;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_a, req1_b;
  logic [3:0]       req1_op;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [31:0]      rsp0_result;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0]      rsp1_result;
  logic [TAG_W-1:0] rsp1_tag;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_tag,
    output req1_valid, req1_a, req1_b, req1_op, req1_tag,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_tag
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_tag
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one 32-bit ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (two request and two response channels)
// One op accepted per cycle; result registered per port and held until the
// port's consumer takes it. Ready is combinational from valid/rsp_ready/prio.

// Combinational 32-bit ALU; unknown op codes yield 0 (zero=1).
module alu_arbiter_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = '0;
    case (op)
      4'd0: result = a + b;
      4'd1: result = a - b;
      4'd2: result = a & b;
      4'd3: result = a | b;
      4'd4: result = a ^ b;
      4'd5: result = {31'd0, $signed(a) < $signed(b)};
      4'd6: result = {31'd0, a < b};
      4'd7: result = a << b[4:0];
      4'd8: result = a >> b[4:0];
      4'd9: result = $unsigned($signed(a) >>> b[4:0]);
      default: result = '0;
    endcase
    zero = (result == 32'd0);
  end
endmodule

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]             req_valid, rsp_ready;
  logic [NUM_PORTS-1:0][31:0]       req_a, req_b;
  logic [NUM_PORTS-1:0][3:0]        req_op;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_PORTS-1:0]             slot_free, elig, grant;

  logic [NUM_PORTS-1:0]             rsp_valid_q, rsp_zero_q;
  logic [NUM_PORTS-1:0][31:0]       rsp_result_q;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  rsp_tag_q;

  logic        prio;   // port that wins when both are eligible
  logic        sel;
  logic [31:0] alu_result;
  logic        alu_zero;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a     = {bus.req1_a,     bus.req0_a};
  assign req_b     = {bus.req1_b,     bus.req0_b};
  assign req_op    = {bus.req1_op,    bus.req0_op};
  assign req_tag   = {bus.req1_tag,   bus.req0_tag};

  // A slot being drained this cycle can be refilled in the same cycle.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign elig      = req_valid & slot_free;

  always_comb begin
    grant = '0;
    if (elig[0] && (!elig[1] || !prio)) grant[0] = 1'b1;
    else if (elig[1])                   grant[1] = 1'b1;
  end

  assign sel = grant[1];

  alu_arbiter_alu u_alu (
    .a      (req_a[sel]),
    .b      (req_b[sel]),
    .op     (req_op[sel]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        prio <= 1'b0;
    else if (grant[0]) prio <= 1'b1;
    else if (grant[1]) prio <= 1'b0;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_q[p]  <= 1'b0;
        rsp_result_q[p] <= '0;
        rsp_zero_q[p]   <= 1'b0;
        rsp_tag_q[p]    <= '0;
      end else if (grant[p]) begin
        // Reload wins over drain: the slot stays valid with the new result.
        rsp_valid_q[p]  <= 1'b1;
        rsp_result_q[p] <= alu_result;
        rsp_zero_q[p]   <= alu_zero;
        rsp_tag_q[p]    <= req_tag[p];
      end else if (rsp_ready[p]) begin
        rsp_valid_q[p]  <= 1'b0;
      end
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp0_zero   = rsp_zero_q[0];
  assign bus.rsp0_tag    = rsp_tag_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp1_zero   = rsp_zero_q[1];
  assign bus.rsp1_tag    = rsp_tag_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scenario tasks for alu_arbiter plus a negedge scoreboard
// monitor that models grants and queues expected responses per port.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(4)) bus ();
  alu_arbiter #(.TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  exp_t sbq [2][$];
  logic mprio = 1'b0;

  function automatic exp_t ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [3:0] tag);
    exp_t e;
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    e.r = r;
    e.z = (r == 32'd0);
    e.t = tag;
    return e;
  endfunction

  // Scoreboard monitor: expected grant from a model priority pointer,
  // expected response from the queue head.
  always @(negedge clk) begin
    logic [1:0] rv, rr, rdy, vout, eg, gx;
    exp_t got;
    if (!rst_n) begin
      sbq[0].delete();
      sbq[1].delete();
      mprio = 1'b0;
    end else begin
      rv   = {bus.req1_valid, bus.req0_valid};
      rr   = {bus.rsp1_ready, bus.rsp0_ready};
      rdy  = {bus.req1_ready, bus.req0_ready};
      vout = {bus.rsp1_valid, bus.rsp0_valid};
      for (int i = 0; i < 2; i++) eg[i] = rv[i] && (sbq[i].size() == 0 || rr[i]);
      gx[0] = eg[0] && (!eg[1] || mprio == 1'b0);
      gx[1] = eg[1] && (!eg[0] || mprio == 1'b1);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rdy[i] !== gx[i]) $display("FAIL grant%0d: got %b want %b at %0t", i, rdy[i], gx[i], $time);
        else passed++;
        total++;
        if (vout[i] !== (sbq[i].size() != 0))
          $display("FAIL rsp%0d_valid: got %b want %b at %0t", i, vout[i], sbq[i].size() != 0, $time);
        else passed++;
        if (sbq[i].size() != 0) begin
          got = (i == 0) ? exp_t'{bus.rsp0_result, bus.rsp0_zero, bus.rsp0_tag}
                         : exp_t'{bus.rsp1_result, bus.rsp1_zero, bus.rsp1_tag};
          total++;
          if (got !== sbq[i][0])
            $display("FAIL rsp%0d_data: got r=%h z=%b t=%h want r=%h z=%b t=%h", i,
                     got.r, got.z, got.t, sbq[i][0].r, sbq[i][0].z, sbq[i][0].t);
          else passed++;
          if (rr[i]) void'(sbq[i].pop_front());
        end
      end
      if (gx[0]) sbq[0].push_back(ref_alu(bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_tag));
      if (gx[1]) sbq[1].push_back(ref_alu(bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_tag));
      if (gx[0]) mprio = 1'b1;
      else if (gx[1]) mprio = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int p, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [3:0] tag);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_tag = tag;
    end
  endtask

  task automatic idle_drain();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_drain();
    @(negedge clk);
    total++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_zero, bus.rsp1_zero} !== 4'b0 ||
        bus.rsp0_result !== 32'd0 || bus.rsp1_result !== 32'd0 ||
        bus.rsp0_tag !== 4'd0 || bus.rsp1_tag !== 4'd0 ||
        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL reset_outputs: got v=%b%b r0=%h r1=%h want all zero",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_result, bus.rsp1_result);
    else passed++;
    tick();
    rst_n = 1;
  endtask

  task automatic test_single();
    bus.rsp0_ready = 1;
    drv(0, 1, 32'd5, 32'd7, 4'd0, 4'd3);
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.req0_ready);
    else passed++;
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd12 || bus.rsp0_zero !== 1'b0 || bus.rsp0_tag !== 4'd3)
      $display("FAIL single_rsp: got v=%b r=%0d z=%b t=%0d want v=1 r=12 z=0 t=3",
               bus.rsp0_valid, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_tag);
    else passed++;
    idle_drain();
  endtask

  task automatic test_contention();
    rst_n = 0; tick(); rst_n = 1;
    drv(0, 1, 32'd9, 32'd9, 4'd1, 4'd1);
    drv(1, 1, 32'hF0, 32'h0F, 4'd4, 4'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.req0_ready !== (c % 2 == 0) || bus.req1_ready !== (c % 2 == 1))
        $display("FAIL contention_grant%0d: got %b%b want %b%b", c, bus.req1_ready, bus.req0_ready,
                 c % 2 == 1, c % 2 == 0);
      else passed++;
      if (c == 1) begin
        total++;
        if (bus.rsp0_result !== 32'd0 || bus.rsp0_zero !== 1'b1)
          $display("FAIL contention_sub: got r=%h z=%b want r=0 z=1", bus.rsp0_result, bus.rsp0_zero);
        else passed++;
      end
      if (c == 2) begin
        total++;
        if (bus.rsp1_result !== 32'hFF) $display("FAIL contention_xor: got %h want ff", bus.rsp1_result);
        else passed++;
      end
      tick();
    end
    idle_drain();
  endtask

  task automatic test_backpressure();
    drv(1, 1, 32'h8000_0000, 32'd4, 4'd9, 4'd7);
    bus.rsp1_ready = 1;
    tick();
    bus.rsp1_ready = 0;
    drv(1, 1, 32'd1, 32'd1, 4'd0, 4'd5);
    drv(0, 1, 32'hFF, 32'h0F, 4'd2, 4'd6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b1 || bus.rsp1_valid !== 1'b1 ||
          bus.rsp1_result !== 32'hF800_0000)
        $display("FAIL bp_hold%0d: got rdy1=%b rdy0=%b v1=%b r1=%h want 0 1 1 f8000000", c,
                 bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp1_result);
      else passed++;
      tick();
    end
    bus.rsp1_ready = 1;
    @(negedge clk);
    total++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0)
      $display("FAIL bp_release: got rdy1=%b rdy0=%b want 1 0", bus.req1_ready, bus.req0_ready);
    else passed++;
    tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.rsp1_result !== 32'd2 || bus.rsp1_tag !== 4'd5)
      $display("FAIL bp_next: got r=%h t=%h want 2 5", bus.rsp1_result, bus.rsp1_tag);
    else passed++;
    idle_drain();
  endtask

  task automatic test_back_to_back();
    bus.rsp0_ready = 1;
    drv(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd5, 4'd1);
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", bus.req0_ready);
    else passed++;
    tick();
    drv(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd6, 4'd2);
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1 || bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd1)
      $display("FAIL b2b_slt: got rdy=%b v=%b r=%h want 1 1 1", bus.req0_ready, bus.rsp0_valid, bus.rsp0_result);
    else passed++;
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd0 || bus.rsp0_zero !== 1'b1)
      $display("FAIL b2b_sltu: got v=%b r=%h z=%b want 1 0 1", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_zero);
    else passed++;
    idle_drain();
  endtask

  task automatic test_illegal_reset();
    bus.rsp1_ready = 0;
    drv(1, 1, 32'd5, 32'd3, 4'hC, 4'd9);
    @(negedge clk);
    total++;
    if (bus.req1_ready !== 1'b1) $display("FAIL illegal_ready: got %b want 1", bus.req1_ready);
    else passed++;
    tick();
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'd0 || bus.rsp1_zero !== 1'b1 || bus.rsp1_tag !== 4'd9)
      $display("FAIL illegal_rsp: got v=%b r=%h z=%b t=%h want 1 0 1 9",
               bus.rsp1_valid, bus.rsp1_result, bus.rsp1_zero, bus.rsp1_tag);
    else passed++;
    #1 rst_n = 0;
    #1;
    total++;
    if (bus.rsp1_valid !== 1'b0 || bus.rsp1_zero !== 1'b0 || bus.rsp1_tag !== 4'd0)
      $display("FAIL async_reset: got v=%b z=%b t=%h want 0 0 0", bus.rsp1_valid, bus.rsp1_zero, bus.rsp1_tag);
    else passed++;
    tick(); tick();
    rst_n = 1;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    drv(0, 1, 32'd1, 32'd2, 4'd0, 4'd1);
    drv(1, 1, 32'd3, 32'd4, 4'd0, 4'd2);
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL prio_after_reset: got rdy0=%b rdy1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    else passed++;
    tick();
    idle_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_illegal_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
